alu: RTL and testbench

ALU -- requirements
Module: alu

---
 rtl/alu_pkg.sv | 16 +
 rtl/alu_addsub.sv | 21 ++
 rtl/alu.sv | 73 +++++++
 tb/tb_alu.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALUControl encodings for the ALU and its adder.
// Used by alu.sv in both configurations (ALU_OUTPUT_REG_EN defined or not).
package alu_pkg;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   // True for the codes that need the adder in subtract mode.
   function automatic logic needs_sub(input logic [2:0] ctrl);
      return (ctrl == ALU_SUB) || (ctrl == ALU_SLT);
   endfunction

endpackage

// File: rtl/alu_addsub.sv
// Shared adder/subtractor for ADD, SUB and SLT.
// Subtraction is a + ~b + 1, with two's-complement overflow reported.
module alu_addsub #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic [WIDTH-1:0] sum,
   output logic             overflow
);

   logic [WIDTH-1:0] b_eff;

   assign b_eff = sub ? ~b : b;
   assign sum   = a + b_eff + {{(WIDTH-1){1'b0}}, sub};

   // Overflow: operands agree in sign but the sum does not.
   assign overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/alu.sv
// Single-cycle ALU: ADD, SUB, AND, OR, SLT and a Zero flag.
// Define ALU_OUTPUT_REG_EN to register the outputs, with an asynchronous active-low reset.
module alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] SrcA,
   input  logic [WIDTH-1:0] SrcB,
   input  logic [2:0]       ALUControl,
   output logic [WIDTH-1:0] ALUResult,
   output logic             Zero
);

   logic [WIDTH-1:0] sum;
   logic             overflow;
   logic             slt_bit;
   logic [WIDTH-1:0] result_p0;
   logic             zero_p0;

   alu_addsub #(.WIDTH(WIDTH)) u_addsub (
      .a        (SrcA),
      .b        (SrcB),
      .sub      (needs_sub(ALUControl)),
      .sum      (sum),
      .overflow (overflow)
   );

   // Sign of the true difference, correcting the wrapped MSB when SrcA - SrcB overflows.
   assign slt_bit = sum[WIDTH-1] ^ overflow;

   always_comb begin
      result_p0 = '0;
      case (ALUControl)
         ALU_ADD: result_p0 = sum;
         ALU_SUB: result_p0 = sum;
         ALU_AND: result_p0 = SrcA & SrcB;
         ALU_OR:  result_p0 = SrcA | SrcB;
         ALU_SLT: result_p0 = {{(WIDTH-1){1'b0}}, slt_bit};
         default: result_p0 = '0;
      endcase
   end

   assign zero_p0 = ~|result_p0;

`ifdef ALU_OUTPUT_REG_EN
   logic [WIDTH-1:0] result_p1;
   logic             zero_p1;

   // Output register stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_p1 <= '0;
         zero_p1   <= 1'b1;
      end else begin
         result_p1 <= result_p0;
         zero_p1   <= zero_p0;
      end
   end

   assign ALUResult = result_p1;
   assign Zero      = zero_p1;
`else
   logic unused_clk_rst;
   assign unused_clk_rst = &{1'b0, clk, rst_n};

   assign ALUResult = result_p0;
   assign Zero      = zero_p0;
`endif

endmodule

// File: tb/tb_alu.sv
// Testbench for alu: directed vector table plus reset/latency sequences.
// Adapts its timing to whether ALU_OUTPUT_REG_EN is defined.
module tb_alu;

   typedef struct {
      string       name;
      logic [2:0]  ctrl;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        zero;
   } vec_t;

   localparam int NVEC = 18;

   logic        clk;
   logic        rst_n;
   logic [31:0] SrcA;
   logic [31:0] SrcB;
   logic [2:0]  ALUControl;
   logic [31:0] ALUResult;
   logic        Zero;

   int tests;
   int fails;
   vec_t vecs [NVEC];

   alu #(.WIDTH(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .SrcA       (SrcA),
      .SrcB       (SrcB),
      .ALUControl (ALUControl),
      .ALUResult  (ALUResult),
      .Zero       (Zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] model(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
      case (c)
         3'b000:  return a + b;
         3'b001:  return a - b;
         3'b010:  return a & b;
         3'b011:  return a | b;
         3'b101:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
      ALUControl = c;
      SrcA       = a;
      SrcB       = b;
   endtask

   // Wait until the presented outputs reflect the driven inputs.
   task automatic settle();
`ifdef ALU_OUTPUT_REG_EN
      @(posedge clk);
      #1;
`else
      #1;
`endif
   endtask

   task automatic run_vec(input vec_t v);
      drive(v.ctrl, v.a, v.b);
      settle();
      check({v.name, "_res"}, ALUResult, v.res);
      check({v.name, "_zero"}, {31'd0, Zero}, {31'd0, v.zero});
      check({v.name, "_model"}, ALUResult, model(v.ctrl, v.a, v.b));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      tests = 0;
      fails = 0;
      vecs[0]  = '{"add_wrap",   3'b000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1};
      vecs[1]  = '{"add_carry",  3'b000, 32'h80E0E0E0, 32'h80203040, 32'h01011120, 1'b0};
      vecs[2]  = '{"sub_eq",     3'b001, 32'h00001234, 32'h00001234, 32'h00000000, 1'b1};
      vecs[3]  = '{"sub_ovf",    3'b001, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b0};
      vecs[4]  = '{"sub_borrow", 3'b001, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0};
      vecs[5]  = '{"and_zero",   3'b010, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h00000000, 1'b1};
      vecs[6]  = '{"and_mix",    3'b010, 32'hF0F0FFFF, 32'h3C3C0001, 32'h30300001, 1'b0};
      vecs[7]  = '{"or_ones",    3'b011, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'hFFFFFFFF, 1'b0};
      vecs[8]  = '{"or_zero",    3'b011, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1};
      vecs[9]  = '{"slt_negneg", 3'b101, 32'hFFFFFF33, 32'hFFFFFFEE, 32'h00000001, 1'b0};
      vecs[10] = '{"slt_posneg", 3'b101, 32'h12345678, 32'hFEDCBA98, 32'h00000000, 1'b1};
      vecs[11] = '{"slt_lt",     3'b101, 32'h00000100, 32'h00000130, 32'h00000001, 1'b0};
      vecs[12] = '{"slt_gt",     3'b101, 32'h00000340, 32'h00000050, 32'h00000000, 1'b1};
      vecs[13] = '{"slt_ovf_lt", 3'b101, 32'h80000000, 32'h00000001, 32'h00000001, 1'b0};
      vecs[14] = '{"slt_ovf_gt", 3'b101, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1'b1};
      vecs[15] = '{"op110",      3'b110, 32'h12341234, 32'hABCDABCD, 32'h00000000, 1'b1};
      vecs[16] = '{"op100",      3'b100, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1};
      vecs[17] = '{"op111",      3'b111, 32'h00000001, 32'h00000001, 32'h00000000, 1'b1};

      rst_n = 1'b1;
      drive(3'b000, 32'h1, 32'h1);
      @(posedge clk);
      #1;

`ifdef ALU_OUTPUT_REG_EN
      @(posedge clk);
      #1;
      check("preload_res", ALUResult, 32'h2);
      // Reset asserted mid-cycle must clear the outputs without a clock edge.
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_async_res", ALUResult, 32'h0);
      check("rst_async_zero", {31'd0, Zero}, 32'd1);
      @(posedge clk);
      #1;
      check("rst_hold_res", ALUResult, 32'h0);
      #2;
      rst_n = 1'b1;
      drive(3'b000, 32'h00001234, 32'h00005678);
      #1;
      check("rel_noedge_res", ALUResult, 32'h0);
      check("rel_noedge_zero", {31'd0, Zero}, 32'd1);
      @(posedge clk);
      #1;
      check("rel_first_res", ALUResult, 32'h000068AC);
      check("rel_first_zero", {31'd0, Zero}, 32'd0);
      // Outputs must hold between edges when inputs change.
      drive(3'b011, 32'hFFFF0000, 32'h0000FFFF);
      #2;
      check("hold_res", ALUResult, 32'h000068AC);
      @(posedge clk);
      #1;
      check("hold_next_res", ALUResult, 32'hFFFFFFFF);
`else
      check("comb_res", ALUResult, 32'h2);
      // Reset has no influence without the output register.
      rst_n = 1'b0;
      drive(3'b000, 32'h00001234, 32'h00005678);
      #1;
      check("rst_noeffect_res", ALUResult, 32'h000068AC);
      check("rst_noeffect_zero", {31'd0, Zero}, 32'd0);
      drive(3'b010, 32'h0000FFFF, 32'hFFFF0000);
      #1;
      check("rst_noeffect_and", ALUResult, 32'h0);
      check("rst_noeffect_and_z", {31'd0, Zero}, 32'd1);
      rst_n = 1'b1;
      #1;
      check("rst_release_res", ALUResult, 32'h0);
`endif

      for (int i = 0; i < NVEC; i++) begin
         run_vec(vecs[i]);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
